// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: fetch PC, prefetch FIFO of {pc, instr}, valid/ready to decode.
// Optional out-of-range fetch fault enabled by defining IMEM_BOUNDS_CHECK_EN.

package imem_fetch_ctrl_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

endpackage

module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned MEM_SIZE   = 58,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [31:0]      fetch_pc_q;
   fetch_entry_t     fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic         full;
   logic         push;
   logic         pop;
   logic         flush;
   logic         pc_oob;
   logic         target_ok;
   logic [31:0]  redirect_target;
   fetch_entry_t head;

`ifdef IMEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;

   logic fault_q;

   // Sticky fault flag mirrors residence in FAULT.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state_d == ST_FAULT);
      end
   end

   assign fetch_fault = fault_q;
`else
   localparam bit BOUNDS_EN = 1'b0;

   assign fetch_fault = 1'b0;
`endif

   assign full            = (count_q == CNT_W'(FIFO_DEPTH));
   assign instr_valid     = (count_q != '0);
   assign pop             = instr_valid & instr_ready;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign pc_oob          = BOUNDS_EN && ({2'b00, fetch_pc_q[31:2]} >= 32'(MEM_SIZE));
   assign target_ok       = !BOUNDS_EN || ({2'b00, redirect_pc[31:2]} < 32'(MEM_SIZE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A redirect only changes state when it is the way out of FAULT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!redirect_valid && fetch_en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!redirect_valid) begin
               if (pc_oob) begin
                  state_d = ST_FAULT;
               end else if (!fetch_en) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FAULT: begin
            if (redirect_valid && target_ok) begin
               state_d = fetch_en ? ST_RUN : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      push  = 1'b0;
      flush = redirect_valid;
      if ((state_q == ST_RUN) && !redirect_valid && !pc_oob && (!full || pop)) begin
         push = 1'b1;
      end
   end

   // Fetch PC and FIFO bookkeeping; a redirect discards everything queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else if (flush) begin
         fetch_pc_q <= redirect_target;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         if (push) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_data};
      end
   end

   assign head      = fifo_q[rd_ptr_q];
   assign imem_addr = fetch_pc_q;
   assign instr     = instr_valid ? head.instr : 32'h0;
   assign instr_pc  = instr_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: streaming, stall, redirect, reset, fetch_en gating, wrap/fault.
module tb_imem_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   imem_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .MEM_SIZE   (58),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   // Memory image: each word is its own address tagged, so pc/instr pairing is visible.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign imem_data = word_at(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      cyc(); cyc();
      rst = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", instr_pc); end
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fetch_fault); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      fetch_en = 1'b1; instr_ready = 1'b1;
      cyc();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_first_idle got %0b exp 0", instr_valid); end
      for (int k = 0; k < 8; k++) begin
         exp_pc = 32'(k * 4);
         cyc();
         checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== word_at(exp_pc)) begin
            errors++; $display("FAIL stream_%0d got v=%0b pc=%h i=%h exp v=1 pc=%h i=%h", k, instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
         end
      end
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL stream_addr got %h exp 00000020", imem_addr); end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      instr_ready = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1C) begin errors++; $display("FAIL stall_head got v=%0b pc=%h exp v=1 pc=0000001c", instr_valid, instr_pc); end
      checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL stall_addr_hold got %h exp 00000024", imem_addr); end
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_pc = 32'h20 + 32'(k * 4);
         cyc();
         checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== word_at(exp_pc)) begin
            errors++; $display("FAIL release_%0d got pc=%h i=%h exp pc=%h i=%h", k, instr_pc, instr, exp_pc, word_at(exp_pc));
         end
      end
      checks++; if (imem_addr !== 32'h34) begin errors++; $display("FAIL release_addr got %h exp 00000034", imem_addr); end
   endtask

   task automatic test_redirect_full();
      instr_ready = 1'b0;
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_00B2;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b exp 0", instr_valid); end
      checks++; if (imem_addr !== 32'hB0) begin errors++; $display("FAIL redir_addr got %h exp 000000b0", imem_addr); end
      cyc();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hB0 || instr !== word_at(32'hB0)) begin
         errors++; $display("FAIL redir_target got v=%0b pc=%h i=%h exp v=1 pc=000000b0 i=%h", instr_valid, instr_pc, instr, word_at(32'hB0));
      end
      cyc();
   endtask

   task automatic test_redirect_pop_and_reset();
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hB0) begin errors++; $display("FAIL rp_popped got v=%0b pc=%h exp v=1 pc=000000b0", instr_valid, instr_pc); end
      cyc();
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL rp_flush got v=%0b addr=%h exp v=0 addr=00000010", instr_valid, imem_addr); end
      cyc();
      checks++; if (instr_pc !== 32'h10) begin errors++; $display("FAIL rp_target got %h exp 00000010", instr_pc); end
      cyc();
      checks++; if (instr_pc !== 32'h14) begin errors++; $display("FAIL rp_next got %h exp 00000014", instr_pc); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst got v=%0b addr=%h exp v=0 addr=00000000", instr_valid, imem_addr); end
      cyc();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got %0b exp 0", instr_valid); end
      cyc();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL midrst_restart got v=%0b pc=%h exp v=1 pc=00000000", instr_valid, instr_pc); end
   endtask

   task automatic test_fetch_en();
      fetch_en = 1'b0;
      cyc();
      checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL en_drain got %h exp 00000004", instr_pc); end
      cyc();
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL en_hold1 got v=%0b addr=%h exp v=0 addr=00000008", instr_valid, imem_addr); end
      cyc();
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL en_hold2 got v=%0b addr=%h exp v=0 addr=00000008", instr_valid, imem_addr); end
      fetch_en = 1'b1;
      cyc();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL en_resume_gap got %0b exp 0", instr_valid); end
      cyc();
      checks++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL en_resume0 got %h exp 00000008", instr_pc); end
      cyc();
      checks++; if (instr_pc !== 32'hC) begin errors++; $display("FAIL en_resume1 got %h exp 0000000c", instr_pc); end
      // Redirect while fetch_en=0 loads the PC but leaves the block idle.
      fetch_en = 1'b0;
      cyc(); cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL en_redir got v=%0b addr=%h exp v=0 addr=00000040", instr_valid, imem_addr); end
      cyc();
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL en_redir_idle got v=%0b addr=%h exp v=0 addr=00000040", instr_valid, imem_addr); end
      fetch_en = 1'b1;
      cyc();
   endtask

`ifndef IMEM_BOUNDS_CHECK_EN
   task automatic test_pc_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", imem_addr); end
      cyc();
      checks++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_last got pc=%h addr=%h exp pc=fffffffc addr=00000000", instr_pc, imem_addr); end
      cyc();
      checks++; if (instr_pc !== 32'h0 || instr !== word_at(32'h0)) begin errors++; $display("FAIL wrap_zero got pc=%h i=%h exp pc=00000000 i=%h", instr_pc, instr, word_at(32'h0)); end
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL wrap_nofault got %0b exp 0", fetch_fault); end
   endtask
`else
   task automatic test_fault();
      redirect_valid = 1'b1; redirect_pc = 32'hE0;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      checks++; if (instr_pc !== 32'hE0) begin errors++; $display("FAIL fault_w56 got %h exp 000000e0", instr_pc); end
      cyc();
      checks++; if (instr_pc !== 32'hE4) begin errors++; $display("FAIL fault_w57 got %h exp 000000e4", instr_pc); end
      cyc();
      checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL fault_set got f=%0b v=%0b exp f=1 v=0", fetch_fault, instr_valid); end
      cyc();
      checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'hE8) begin errors++; $display("FAIL fault_sticky got f=%0b v=%0b addr=%h exp f=1 v=0 addr=000000e8", fetch_fault, instr_valid, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      cyc();
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_bad_redir got %0b exp 1", fetch_fault); end
      redirect_pc = 32'h0;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL fault_clear got f=%0b addr=%h exp f=0 addr=00000000", fetch_fault, imem_addr); end
      cyc();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL fault_resume got v=%0b pc=%h exp v=1 pc=00000000", instr_valid, instr_pc); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_redirect_pop_and_reset();
      test_fetch_en();
`ifndef IMEM_BOUNDS_CHECK_EN
      test_pc_wrap();
`else
      test_fault();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
